// File: rtl/pdp_fifo_ctrl_if.sv
// Stream-side handshake bundle of pdp_fifo_ctrl: valid/ready input stream and FWFT output stream.
// The slave modport is the controller view; master is the view of the surrounding logic.
interface pdp_fifo_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_WIDTH-1:0] s_data_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;

    modport slave (
        input  s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o
    );

    modport master (
        output s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/pdp_fifo_ctrl.sv
// FIFO controller in front of a pseudo-dual-port RAM: sequential writes, prefetched reads
// into a small output buffer so the output side behaves as a first-word-fall-through stream.
module pdp_fifo_ctrl #(
    parameter int unsigned ADDR_DEPTH   = 512,
    parameter int unsigned ADDR_WIDTH   = $clog2(ADDR_DEPTH),
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned AFULL_THRESH = ADDR_DEPTH - 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    pdp_fifo_ctrl_if.slave        bus,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o
);
    localparam int unsigned OBUF_DEPTH = RD_LATENCY + 1;
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned OB_W       = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned OCC_W      = OB_W + 1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  mem_cnt_q, mem_cnt_d;
    logic [RD_LATENCY-1:0] infl_q, infl_d;
    logic [DATA_WIDTH-1:0] obuf_q [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0] obuf_d [OBUF_DEPTH];
    logic [OB_W-1:0]       obuf_cnt_q, obuf_cnt_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  push, pop, issue, capture;
    logic [OB_W-1:0]       cap_idx;

    function automatic logic [OB_W-1:0] popcnt(input logic [RD_LATENCY-1:0] v);
        logic [OB_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            n = n + OB_W'(v[i]);
        end
        return n;
    endfunction

    assign full_o        = (mem_cnt_q == CNT_WIDTH'(ADDR_DEPTH));
    assign bus.s_ready_o = rst_n_i & ~full_o & ~flush_i;
    assign bus.m_valid_o = (obuf_cnt_q != '0);
    assign bus.m_data_o  = obuf_q[0];
    assign push          = bus.s_valid_i & bus.s_ready_o;
    assign pop           = bus.m_valid_o & bus.m_ready_i;
    assign capture       = infl_q[RD_LATENCY-1];

    // Reads are only issued when the buffer is guaranteed to have room once they return.
    assign issue = rst_n_i & ~flush_i & (mem_cnt_q != '0) &
                   ((OCC_W'(obuf_cnt_q) + OCC_W'(popcnt(infl_q)) - OCC_W'(pop)) < OCC_W'(OBUF_DEPTH));

    assign ram_wr_en_o   = push;
    assign ram_wr_addr_o = wptr_q;
    assign ram_wr_data_o = bus.s_data_i;
    assign ram_rd_en_o   = issue;
    assign ram_rd_addr_o = rptr_q;
    assign count_o       = count_q;
    assign empty_o       = empty_q;
    assign almost_full_o = afull_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = (wptr_q == ADDR_WIDTH'(ADDR_DEPTH - 1)) ? '0 : wptr_q + ADDR_WIDTH'(1);
        end
        if (issue) begin
            rptr_d = (rptr_q == ADDR_WIDTH'(ADDR_DEPTH - 1)) ? '0 : rptr_q + ADDR_WIDTH'(1);
        end
        mem_cnt_d = mem_cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(issue);
        // Truncating the concatenation shifts issue in at bit 0 for any latency, including 1.
        infl_d = RD_LATENCY'({infl_q, issue});
    end

    always_comb begin
        obuf_d  = obuf_q;
        cap_idx = obuf_cnt_q - OB_W'(pop);
        if (pop) begin
            for (int unsigned i = 0; i + 1 < OBUF_DEPTH; i++) begin
                obuf_d[i] = obuf_q[i+1];
            end
            obuf_d[OBUF_DEPTH-1] = '0;
        end
        if (capture) begin
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                if (OB_W'(i) == cap_idx) begin
                    obuf_d[i] = ram_rd_data_i;
                end
            end
        end
        obuf_cnt_d = obuf_cnt_q + OB_W'(capture) - OB_W'(pop);
        count_d    = mem_cnt_d + CNT_WIDTH'(obuf_cnt_d) + CNT_WIDTH'(popcnt(infl_d));
        empty_d    = (count_d == '0);
        afull_d    = (count_d >= CNT_WIDTH'(AFULL_THRESH));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            infl_q     <= '0;
            obuf_cnt_q <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                obuf_q[i] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            infl_q     <= infl_d;
            obuf_cnt_q <= obuf_cnt_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                obuf_q[i] <= obuf_d[i];
            end
        end
    end
endmodule
